// File: rtl/mil1553_pkg.sv
// Shared MIL-STD-1553 constants and types used by the Manchester encoder and decoder.
package mil1553_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY
  } state_t;

  localparam int SYNC_HALVES  = 6;
  localparam int DATA_BITS    = 16;
  localparam int WORD_HALVES  = 40;
  localparam int PARITY_FIRST = SYNC_HALVES + 2 * DATA_BITS;

  // Sync levels listed with half-bit 0 in the MSB position
  localparam logic [SYNC_HALVES-1:0] SYNC_CMD  = 6'b111000;
  localparam logic [SYNC_HALVES-1:0] SYNC_DATA = 6'b000111;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/mil1553_half_tick.sv
// Half-bit timebase: counts 0..HALF-1 while a word is running and pulses tick on the last count.
module mil1553_half_tick #(
  parameter int HALF = 50
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear || !run || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // pre_tick lets the encoder register s_ready so it is high during the tick clock itself
  assign tick     = run && (count == CW'(HALF - 1));
  assign pre_tick = run && (count == CW'(HALF - 2));

endmodule

// File: rtl/mil1553_encoder.sv
// MIL-STD-1553 Manchester II word transmitter driving a differential PMOD transceiver pair.
module mil1553_encoder
  import mil1553_pkg::*;
#(
  parameter int CLOCK_SPEED = 100000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] s_data,
  input  logic        s_cmd,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        diff_p,
  output logic        diff_n,
  output logic        tx_en,
  output logic        busy
);

  localparam int HALF = CLOCK_SPEED / 2000000;
  localparam logic [5:0] LAST_HALF = 6'(WORD_HALVES - 1);

  state_t               state, state_nx;
  logic [5:0]           idx, idx_nx;
  logic [DATA_BITS:0]   shreg, shreg_nx;
  logic                 cmd_flag, cmd_nx;
  logic                 tick, pre_tick, accept, running;
  logic                 level_nx, active_nx, ready_nx;
  logic [SYNC_HALVES-1:0] sync_pat;
  logic [2:0]           sync_pos;

  assign accept  = s_valid && s_ready;
  assign running = (state != ST_IDLE);

  mil1553_half_tick #(.HALF(HALF)) u_half_tick (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (accept),
    .run      (running),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      idx      <= '0;
      shreg    <= '0;
      cmd_flag <= 1'b0;
      s_ready  <= 1'b0;
      diff_p   <= 1'b0;
      diff_n   <= 1'b0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      shreg    <= shreg_nx;
      cmd_flag <= cmd_nx;
      s_ready  <= ready_nx;
      diff_p   <= active_nx & level_nx;
      diff_n   <= active_nx & ~level_nx;
      tx_en    <= active_nx;
      busy     <= active_nx;
    end
  end

  // Shift register moves after each completed data bit so bit 16 always holds the current bit
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    shreg_nx = shreg;
    cmd_nx   = cmd_flag;
    if (accept) begin
      state_nx = ST_SYNC;
      idx_nx   = '0;
      shreg_nx = {s_data, odd_parity(s_data)};
      cmd_nx   = s_cmd;
    end else if (tick) begin
      if (idx == LAST_HALF) begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
      end else begin
        idx_nx = idx + 6'd1;
        if (state == ST_DATA && idx[0]) begin
          shreg_nx = {shreg[DATA_BITS-1:0], 1'b0};
        end
        if (idx_nx == 6'(SYNC_HALVES)) begin
          state_nx = ST_DATA;
        end else if (idx_nx == 6'(PARITY_FIRST)) begin
          state_nx = ST_PARITY;
        end
      end
    end
  end

  // Outputs are derived from the next state so the registered pins line up with the state change
  always_comb begin
    active_nx = (state_nx != ST_IDLE);
    ready_nx  = (state_nx == ST_IDLE) || (idx_nx == LAST_HALF && pre_tick);
    sync_pat  = cmd_nx ? SYNC_CMD : SYNC_DATA;
    sync_pos  = 3'(SYNC_HALVES - 1) - idx_nx[2:0];
    level_nx  = 1'b0;
    case (state_nx)
      ST_SYNC:            level_nx = sync_pat[sync_pos];
      ST_DATA, ST_PARITY: level_nx = shreg_nx[DATA_BITS] ^ idx_nx[0];
      default:            level_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mil1553_encoder.sv
// Directed bench for mil1553_encoder at 100 MHz and 50 MHz clock settings.
module tb_mil1553_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] a_data, b_data;
  logic        a_cmd, b_cmd, a_valid, b_valid;
  logic        a_ready, a_p, a_n, a_en, a_busy;
  logic        b_ready, b_p, b_n, b_en, b_busy;

  mil1553_encoder #(.CLOCK_SPEED(100000000)) dut_a (
    .clk(clk), .resetn(resetn), .s_data(a_data), .s_cmd(a_cmd), .s_valid(a_valid),
    .s_ready(a_ready), .diff_p(a_p), .diff_n(a_n), .tx_en(a_en), .busy(a_busy)
  );

  mil1553_encoder #(.CLOCK_SPEED(50000000)) dut_b (
    .clk(clk), .resetn(resetn), .s_data(b_data), .s_cmd(b_cmd), .s_valid(b_valid),
    .s_ready(b_ready), .diff_p(b_p), .diff_n(b_n), .tx_en(b_en), .busy(b_busy)
  );

  bit   sel = 1'b0;
  logic obs_p, obs_n, obs_en, obs_busy, obs_ready;
  assign obs_p     = sel ? b_p     : a_p;
  assign obs_n     = sel ? b_n     : a_n;
  assign obs_en    = sel ? b_en    : a_en;
  assign obs_busy  = sel ? b_busy  : a_busy;
  assign obs_ready = sel ? b_ready : a_ready;

  int   cmp_cnt  = 0;
  int   fail_cnt = 0;
  logic p_hist [0:1999];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    cmp_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit to_b, input logic valid, input logic cmd, input logic [15:0] data);
    if (to_b) begin
      b_valid = valid; b_cmd = cmd; b_data = data;
    end else begin
      a_valid = valid; a_cmd = cmd; a_data = data;
    end
  endtask

  // Reference bus level for half-bit h of a word, built from the 1553 word format
  function automatic logic exp_level(input logic cmd, input logic [15:0] data, input int h);
    logic b;
    if (h < 6) return cmd ? (h < 3) : (h >= 3);
    if (h < 38) b = data[15 - (h - 6) / 2];
    else        b = ~^data;
    return (h % 2 == 0) ? b : ~b;
  endfunction

  // Follows one word already handed over on the coming edge; drives the next inputs on its final clock
  task automatic check_word(input string tag, input bit use_b, input logic cmd, input logic [15:0] data,
                            input bit noise, input logic nxt_valid, input logic nxt_cmd, input logic [15:0] nxt_data);
    int   half  = use_b ? 25 : 50;
    int   total = 40 * half;
    int   bad_lvl = 0, bad_act = 0, bad_rdy = 0;
    logic l;
    sel = use_b;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      l = exp_level(cmd, data, c / half);
      p_hist[c] = obs_p;
      if (obs_p !== l || obs_n !== ~l) bad_lvl++;
      if (obs_en !== 1'b1 || obs_busy !== 1'b1) bad_act++;
      if (obs_ready !== (c == total - 1)) bad_rdy++;
      if (c == total - 1) apply_stimulus(use_b, nxt_valid, nxt_cmd, nxt_data);
      else if (noise)     apply_stimulus(use_b, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
      else                apply_stimulus(use_b, 1'b0, cmd, data);
    end
    check_output({tag, "_level_errs"}, bad_lvl, 0);
    check_output({tag, "_active_errs"}, bad_act, 0);
    check_output({tag, "_ready_errs"}, bad_rdy, 0);
  endtask

  task automatic spot(input string tag, input int c, input logic expected);
    check_output($sformatf("%s_p%0d", tag, c), p_hist[c], expected);
  endtask

  task automatic check_idle(input string tag, input bit use_b);
    sel = use_b;
    @(negedge clk);
    check_output(tag, {obs_ready, obs_p, obs_n, obs_en, obs_busy}, 5'b10000);
  endtask

  task automatic start_word(input string tag, input bit use_b, input logic cmd, input logic [15:0] data);
    sel = use_b;
    check_output({tag, "_ready_before"}, obs_ready, 1'b1);
    apply_stimulus(use_b, 1'b1, cmd, data);
  endtask

  initial begin
    resetn = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    check_output("reset_a", {a_ready, a_p, a_n, a_en, a_busy}, 5'b00000);
    check_output("reset_b", {b_ready, b_p, b_n, b_en, b_busy}, 5'b00000);
    resetn = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset_a", a_ready, 1'b1);
    check_output("ready_after_reset_b", b_ready, 1'b1);

    // Command sync, all-zero data, parity 1
    start_word("w0000", 1'b0, 1'b1, 16'h0000);
    check_word("w0000", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    spot("w0000", 0, 1'b1);    spot("w0000", 149, 1'b1);  spot("w0000", 150, 1'b0);
    spot("w0000", 300, 1'b0);  spot("w0000", 349, 1'b0);  spot("w0000", 350, 1'b1);
    spot("w0000", 1900, 1'b1); spot("w0000", 1950, 1'b0);
    check_idle("idle_after_w0000", 1'b0);

    // Data sync, all-ones data; sixteen ones give odd parity bit 1
    start_word("wFFFF", 1'b0, 1'b0, 16'hFFFF);
    check_word("wFFFF", 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000);
    spot("wFFFF", 0, 1'b0);    spot("wFFFF", 149, 1'b0);  spot("wFFFF", 150, 1'b1);
    spot("wFFFF", 300, 1'b1);  spot("wFFFF", 350, 1'b0);
    spot("wFFFF", 1900, 1'b1); spot("wFFFF", 1950, 1'b0);
    check_idle("idle_after_wFFFF", 1'b0);

    // Back-to-back words with s_valid held across the boundary
    start_word("wA5A5", 1'b0, 1'b1, 16'hA5A5);
    check_word("wA5A5", 1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 16'h1234);
    check_word("w1234", 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000);
    spot("w1234", 0, 1'b0);    spot("w1234", 150, 1'b1);  spot("w1234", 300, 1'b0);
    spot("w1234", 350, 1'b1);  spot("w1234", 600, 1'b1);
    spot("w1234", 1900, 1'b0); spot("w1234", 1950, 1'b1);
    check_idle("idle_after_w1234", 1'b0);

    // Producer offers changing words mid-word; only the final-clock offer may be taken
    start_word("w0F0F", 1'b0, 1'b1, 16'h0F0F);
    check_word("w0F0F", 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b0, 16'hC3C3);
    check_word("wC3C3", 1'b0, 1'b0, 16'hC3C3, 1'b0, 1'b0, 1'b0, 16'h0000);
    spot("wC3C3", 0, 1'b0);    spot("wC3C3", 300, 1'b1);  spot("wC3C3", 1900, 1'b1);
    check_idle("idle_after_wC3C3", 1'b0);

    // Reset pulse at half-bit 20 abandons the word
    start_word("w5555", 1'b0, 1'b0, 16'h5555);
    for (int c = 0; c <= 1000; c++) begin
      @(negedge clk);
      if (c == 0) apply_stimulus(1'b0, 1'b0, 1'b0, 16'h5555);
    end
    check_output("w5555_midword_txen", a_en, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check_output("midreset_outputs", {a_ready, a_p, a_n, a_en, a_busy}, 5'b00000);
    resetn = 1'b1;
    check_idle("ready_after_midreset", 1'b0);
    start_word("wBEEF", 1'b0, 1'b1, 16'hBEEF);
    check_word("wBEEF", 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000);
    spot("wBEEF", 0, 1'b1);    spot("wBEEF", 300, 1'b1);  spot("wBEEF", 350, 1'b0);
    spot("wBEEF", 1900, 1'b0);
    check_idle("idle_after_wBEEF", 1'b0);

    // 50 MHz instance: 25-clock half-bits, 1000-clock word, parity 1
    @(negedge clk);
    start_word("w8001", 1'b1, 1'b1, 16'h8001);
    check_word("w8001", 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 16'h0000);
    spot("w8001", 0, 1'b1);   spot("w8001", 74, 1'b1);   spot("w8001", 75, 1'b0);
    spot("w8001", 150, 1'b1); spot("w8001", 175, 1'b0);  spot("w8001", 200, 1'b0);
    spot("w8001", 900, 1'b1); spot("w8001", 950, 1'b1);  spot("w8001", 975, 1'b0);
    check_idle("idle_after_w8001", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
